// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_hi;
  logic [DATA_W-1:0] out_lo;
  logic              busy;

  modport master (
    output flush, in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_hi, out_lo, busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit producing a HI/LO pair.
// Operands are iterated as magnitudes; signs are applied in a single FIX cycle.
module mul_div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input logic            clk,
  input logic            resetn,
  mul_div_unit_if.slave  io
);
  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic                div0_q, div0_d;

  logic                accept, dec_div, dec_signed, sa, sb, rem_ge;
  logic [DATA_W-1:0]   mag_a, mag_b, quo, rem;
  logic [DATA_W:0]     add_sum, rem_sh, rem_sub;
  logic [2*DATA_W-1:0] prod_neg;

  assign io.in_ready  = resetn & ~io.flush &
                        ((state_q == IDLE) | ((state_q == DONE) & io.out_ready));
  assign accept       = io.in_valid & io.in_ready;
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.out_hi    = hi_q;
  assign io.out_lo    = lo_q;

  // Lowest set op bit wins; an all-zero op falls through to MULTU.
  always_comb begin
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    if (io.in_op[0]) begin
      dec_signed = 1'b1;
    end else if (!io.in_op[1] && io.in_op[2]) begin
      dec_div    = 1'b1;
      dec_signed = 1'b1;
    end else if (!io.in_op[1] && io.in_op[3]) begin
      dec_div    = 1'b1;
    end
  end

  assign sa    = dec_signed & io.in_src1[DATA_W-1];
  assign sb    = dec_signed & io.in_src2[DATA_W-1];
  assign mag_a = sa ? ('0 - io.in_src1) : io.in_src1;
  assign mag_b = sb ? ('0 - io.in_src2) : io.in_src2;

  // Partial remainder stays below the divisor, so the subtract MSB is a clean borrow flag.
  assign add_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opb_q};
  assign rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
  assign rem_sub  = rem_sh - {1'b0, opb_q};
  assign rem_ge   = ~rem_sub[DATA_W];
  assign prod_neg = '0 - acc_q;
  assign quo      = neg_q  ? ('0 - acc_q[DATA_W-1:0])        : acc_q[DATA_W-1:0];
  assign rem      = rneg_q ? ('0 - acc_q[2*DATA_W-1:DATA_W]) : acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    src1_d   = src1_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;

    case (state_q)
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = {(rem_ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0]),
                   acc_q[DATA_W-2:0], rem_ge};
        end else begin
          acc_d = {(acc_q[0] ? add_sum : {1'b0, acc_q[2*DATA_W-1:DATA_W]}),
                   acc_q[DATA_W-1:1]};
        end
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = div0_q ? src1_q : rem;
          lo_d = div0_q ? '1     : quo;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      state_d  = CALC;
      cnt_d    = '0;
      is_div_d = dec_div;
      neg_d    = sa ^ sb;
      rneg_d   = sa;
      div0_d   = dec_div & (io.in_src2 == '0);
      src1_d   = io.in_src1;
      opb_d    = dec_div ? mag_b : mag_a;
      acc_d    = {{DATA_W{1'b0}}, (dec_div ? mag_a : mag_b)};
    end

    if (io.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      src1_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      src1_q   <= src1_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at DATA_W=32 and DATA_W=8.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.DATA_W(32)) b32 ();
  mul_div_unit_if #(.DATA_W(8))  b8 ();

  mul_div_unit #(.DATA_W(32)) dut32 (.clk(clk), .resetn(resetn), .io(b32.slave));
  mul_div_unit #(.DATA_W(8))  dut8  (.clk(clk), .resetn(resetn), .io(b8.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request in an idle cycle and returns the cycle number of the first out_valid.
  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
    b32.in_op = op; b32.in_src1 = a; b32.in_src2 = b; b32.in_valid = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    lat = 1;
    while (!b32.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    b8.in_op = op; b8.in_src1 = a; b8.in_src2 = b; b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    lat = 1;
    while (!b8.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    b32.flush = 0; b32.in_valid = 0; b32.in_op = '0; b32.in_src1 = '0; b32.in_src2 = '0;
    b32.out_ready = 1'b1;
    b8.flush = 0; b8.in_valid = 0; b8.in_op = '0; b8.in_src1 = '0; b8.in_src2 = '0;
    b8.out_ready = 1'b1;
    tick(); tick();
    vectors++; if ({b32.out_valid, b32.busy, b32.in_ready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctl32: got %b expected 000", {b32.out_valid, b32.busy, b32.in_ready}); end
    vectors++; if ({b32.out_hi, b32.out_lo} !== 64'h0) begin
      miscompares++; $display("FAIL reset_data32: got %h expected 0", {b32.out_hi, b32.out_lo}); end
    vectors++; if ({b8.out_valid, b8.busy, b8.in_ready, b8.out_hi, b8.out_lo} !== 19'h0) begin
      miscompares++; $display("FAIL reset_dut8: got %h expected 0", {b8.out_valid, b8.busy, b8.in_ready, b8.out_hi, b8.out_lo}); end
    resetn = 1'b1;
    #1;
    vectors++; if (b32.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %b expected 1", b32.in_ready); end
  endtask

  task automatic test_mult;
    logic [3:0]  t_op [3] = '{4'b0001, 4'b0010, 4'b0001};
    logic [31:0] t_a  [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_b  [3] = '{32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_hi [3] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000};
    logic [31:0] t_lo [3] = '{32'hFFFFFFF1, 32'h00000001, 32'h00000001};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue32(t_op[i], t_a[i], t_b[i], lat);
      vectors++; if (lat !== 34) begin
        miscompares++; $display("FAIL mult_latency[%0d]: got %0d expected 34", i, lat); end
      vectors++; if (b32.out_hi !== t_hi[i] || b32.out_lo !== t_lo[i]) begin
        miscompares++; $display("FAIL mult_result[%0d]: got %h_%h expected %h_%h", i, b32.out_hi, b32.out_lo, t_hi[i], t_lo[i]); end
      tick();
      vectors++; if (b32.in_ready !== 1'b1 || b32.busy !== 1'b0) begin
        miscompares++; $display("FAIL mult_idle[%0d]: got ready=%b busy=%b expected ready=1 busy=0", i, b32.in_ready, b32.busy); end
    end
  endtask

  task automatic test_op_decode;
    logic [3:0]  t_op [3] = '{4'b0000, 4'b0101, 4'b1100};
    logic [31:0] t_a  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [31:0] t_b  [3] = '{32'h00000002, 32'h00000002, 32'h00000002};
    logic [31:0] t_hi [3] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_lo [3] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue32(t_op[i], t_a[i], t_b[i], lat);
      vectors++; if (b32.out_hi !== t_hi[i] || b32.out_lo !== t_lo[i]) begin
        miscompares++; $display("FAIL decode[%0d]: got %h_%h expected %h_%h", i, b32.out_hi, b32.out_lo, t_hi[i], t_lo[i]); end
      tick();
    end
  endtask

  // The last vector's result is relied on by test_flush as the held value.
  task automatic test_div;
    logic [3:0]  t_op [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    logic [31:0] t_a  [5] = '{32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFF9, 32'h00000007, 32'h12345678};
    logic [31:0] t_b  [5] = '{32'h00000002, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'h00000000};
    logic [31:0] t_hi [5] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFF9, 32'h00000001, 32'h12345678};
    logic [31:0] t_lo [5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue32(t_op[i], t_a[i], t_b[i], lat);
      vectors++; if (lat !== 34) begin
        miscompares++; $display("FAIL div_latency[%0d]: got %0d expected 34", i, lat); end
      vectors++; if (b32.out_hi !== t_hi[i] || b32.out_lo !== t_lo[i]) begin
        miscompares++; $display("FAIL div_result[%0d]: got %h_%h expected %h_%h", i, b32.out_hi, b32.out_lo, t_hi[i], t_lo[i]); end
      tick();
    end
  endtask

  task automatic test_flush;
    int seen = 0;
    b32.in_op = 4'b1000; b32.in_src1 = 32'd100; b32.in_src2 = 32'd3; b32.in_valid = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    repeat (9) tick();
    b32.flush = 1'b1; b32.in_valid = 1'b1;
    #1;
    vectors++; if (b32.in_ready !== 1'b0 || b32.busy !== 1'b1) begin
      miscompares++; $display("FAIL flush_cycle: got ready=%b busy=%b expected ready=0 busy=1", b32.in_ready, b32.busy); end
    tick();
    b32.flush = 1'b0; b32.in_valid = 1'b0;
    #1;
    vectors++; if (b32.busy !== 1'b0 || b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_after: got busy=%b ready=%b valid=%b expected 0 1 0", b32.busy, b32.in_ready, b32.out_valid); end
    vectors++; if (b32.out_hi !== 32'h12345678 || b32.out_lo !== 32'hFFFFFFFF) begin
      miscompares++; $display("FAIL flush_hold: got %h_%h expected 12345678_ffffffff", b32.out_hi, b32.out_lo); end
    for (int i = 0; i < 40; i++) begin
      if (b32.out_valid) seen++;
      tick();
    end
    vectors++; if (seen !== 0) begin
      miscompares++; $display("FAIL flush_no_valid: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_reset_mid;
    b32.in_op = 4'b0001; b32.in_src1 = 32'd7; b32.in_src2 = 32'd9; b32.in_valid = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    vectors++; if (b32.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_ready_low: got %b expected 0", b32.in_ready); end
    tick();
    vectors++; if ({b32.out_valid, b32.busy, b32.out_hi, b32.out_lo} !== 66'h0) begin
      miscompares++; $display("FAIL rst_mid_outputs: got %h expected 0", {b32.out_valid, b32.busy, b32.out_hi, b32.out_lo}); end
    resetn = 1'b1;
    #1;
    vectors++; if (b32.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_release: got %b expected 1", b32.in_ready); end
  endtask

  task automatic test_backpressure;
    int lat;
    b32.out_ready = 1'b0;
    issue32(4'b0100, 32'd100, 32'd7, lat);
    vectors++; if (lat !== 34) begin
      miscompares++; $display("FAIL bp_latency: got %0d expected 34", lat); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0 ||
                     b32.out_hi !== 32'd2 || b32.out_lo !== 32'd14) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got v=%b r=%b %h_%h expected v=1 r=0 00000002_0000000e",
                                i, b32.out_valid, b32.in_ready, b32.out_hi, b32.out_lo); end
      tick();
    end
    b32.out_ready = 1'b1;
    b32.in_op = 4'b0010; b32.in_src1 = 32'd6; b32.in_src2 = 32'd7; b32.in_valid = 1'b1;
    #1;
    vectors++; if (b32.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release_ready: got %b expected 1", b32.in_ready); end
    tick();
    b32.in_valid = 1'b0;
    lat = 1;
    while (!b32.out_valid && lat < 100) begin tick(); lat++; end
    vectors++; if (lat !== 34 || b32.out_hi !== 32'd0 || b32.out_lo !== 32'd42) begin
      miscompares++; $display("FAIL bp_next_op: got lat=%0d %h_%h expected lat=34 00000000_0000002a", lat, b32.out_hi, b32.out_lo); end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat;
    b32.in_op = 4'b0010; b32.in_src1 = 32'd1000; b32.in_src2 = 32'd1000; b32.in_valid = 1'b1;
    tick();
    b32.in_op = 4'b1000; b32.in_src1 = 32'd1000; b32.in_src2 = 32'd33;
    lat = 1;
    while (!b32.out_valid && lat < 100) begin tick(); lat++; end
    vectors++; if (lat !== 34 || b32.out_lo !== 32'd1000000 || b32.out_hi !== 32'd0) begin
      miscompares++; $display("FAIL b2b_first: got lat=%0d %h_%h expected lat=34 00000000_000f4240", lat, b32.out_hi, b32.out_lo); end
    vectors++; if (b32.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_ready: got %b expected 1", b32.in_ready); end
    tick();
    b32.in_valid = 1'b0;
    lat = 1;
    while (!b32.out_valid && lat < 100) begin tick(); lat++; end
    vectors++; if (lat !== 34 || b32.out_lo !== 32'd30 || b32.out_hi !== 32'd10) begin
      miscompares++; $display("FAIL b2b_second: got lat=%0d %h_%h expected lat=34 0000000a_0000001e", lat, b32.out_hi, b32.out_lo); end
    tick();
  endtask

  task automatic test_dw8;
    logic [3:0] t_op [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    logic [7:0] t_a  [4] = '{8'h80, 8'h81, 8'hFF, 8'hFF};
    logic [7:0] t_b  [4] = '{8'h80, 8'h03, 8'hFF, 8'h10};
    logic [7:0] t_hi [4] = '{8'h40, 8'hFF, 8'hFE, 8'h0F};
    logic [7:0] t_lo [4] = '{8'h00, 8'hD6, 8'h01, 8'h0F};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue8(t_op[i], t_a[i], t_b[i], lat);
      vectors++; if (lat !== 10) begin
        miscompares++; $display("FAIL dw8_latency[%0d]: got %0d expected 10", i, lat); end
      vectors++; if (b8.out_hi !== t_hi[i] || b8.out_lo !== t_lo[i]) begin
        miscompares++; $display("FAIL dw8_result[%0d]: got %h_%h expected %h_%h", i, b8.out_hi, b8.out_lo, t_hi[i], t_lo[i]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_op_decode();
    test_div();
    test_flush();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_dw8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit that extends the single-cycle ALU with MULT, MULTU, DIV and DIVU, producing a HI/LO result pair. It sits beside the ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake and computes one radix-2 iteration per cycle. The result is held until the consumer takes it. A flush input lets the pipeline abandon an in-flight operation on exception or branch recovery.

## Interface
Parameters:
- DATA_W, default 32: operand and result width. Must be ≥ 4.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- resetn  in  1  synchronous active-low reset
- flush  in  1  drop the in-flight operation and any held result
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- in_op  in  4  one-hot select: [0] MULT (signed), [1] MULTU, [2] DIV (signed), [3] DIVU
- in_src1  in  DATA_W  multiplicand or dividend
- in_src2  in  DATA_W  multiplier or divisor
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result this cycle
- out_hi  out  DATA_W  upper product half, or remainder
- out_lo  out  DATA_W  lower product half, or quotient
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: wait for a request.
  - CALC: iterate, counter 0..DATA_W-1.
  - FIX: sign correction and result register load.
  - DONE: hold result.
- in_ready = ~flush & ((state==IDLE) | (state==DONE & out_ready)).
- Accept occurs when in_valid & in_ready. On accept:
  - Latch the op and the operand magnitudes (abs for signed ops) and the sign flags.
  - Clear the counter and go to CALC.
- Op decode: the lowest-index set bit of in_op wins. in_op==0 executes as MULTU.
- CALC, multiply: shift-add on a 2·DATA_W accumulator, one multiplier bit per cycle.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- After iteration DATA_W-1, go to FIX.
- FIX, multiply: negate the 2·DATA_W product if the signed op had operand signs that differ.
- FIX, divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- FIX writes out_hi/out_lo, then goes to DONE.
- Result placement:
  - Multiply: {out_hi,out_lo} = full 2·DATA_W product.
  - Divide: out_lo = quotient, out_hi = remainder.
- Divide by zero (signed or unsigned): out_lo = all ones, out_hi = in_src1. No exception is raised.
- Signed overflow (MIN / -1): out_lo = MIN, out_hi = 0.
- DONE holds out_valid=1 with stable out_hi/out_lo until out_ready.
  - out_ready without a new accept: go to IDLE.
  - out_ready with a simultaneous accept: go straight to CALC.
- flush (any state) has priority over everything except reset:
  - Next state is IDLE and out_valid is 0 from the next cycle.
  - No accept is possible in a flush cycle.
  - out_hi/out_lo keep their old value.
- Reset (resetn=0 at an edge), including mid-operation:
  - state=IDLE, out_valid=0, out_hi=0, out_lo=0, counter=0, busy=0.
  - in_ready is 0 while resetn is low and 1 in the first cycle after release.

## Timing
- Accept in cycle 0 gives: CALC in cycles 1..DATA_W, FIX in cycle DATA_W+1, out_valid=1 in cycle DATA_W+2. For DATA_W=32 that is cycle 34.
- Latency is fixed and independent of operand values and op.
- Back-to-back throughput is one op per DATA_W+2 cycles when out_ready is held high.
- in_ready is combinational from state, flush and out_ready. No other output is combinational from inputs.
- busy is 1 in every CALC, FIX and DONE cycle.

## Test plan
- MULT -3 × 5 (DATA_W=32), out_ready=1 → out_valid first high in cycle 34, out_hi=FFFFFFFF, out_lo=FFFFFFF1, then in_ready=1.
- MULTU FFFFFFFF × FFFFFFFF → out_hi=FFFFFFFE, out_lo=00000001. MULT on the same operands → out_hi=0, out_lo=1.
- Signed and zero-divisor divides:
  - DIV -7 / 2 → out_lo=FFFFFFFD, out_hi=FFFFFFFF.
  - DIV 80000000 / FFFFFFFF → out_lo=80000000, out_hi=0.
  - DIVU 12345678 / 0 → out_lo=FFFFFFFF, out_hi=12345678.
- Flush and reset mid-operation:
  - Accept DIVU, assert flush in cycle 10 → busy=0 and in_ready=1 in cycle 11, no out_valid ever.
  - Reset mid-CALC → all outputs 0 in the next cycle.
- Backpressure: out_ready=0 for 5 cycles after out_valid → result stable and in_ready=0 throughout. Then out_ready=1 with in_valid=1 → new op accepted that cycle, next out_valid DATA_W+2 cycles later.
- DATA_W=8:
  - MULT 0x80 × 0x80 → out_hi=0x40, out_lo=0x00, latency 10.
  - DIV 0x81 / 0x03 → out_lo=0xD6, out_hi=0xFF.
